// File: rtl/timer_seq_ctrl.sv
// Sequencer ahead of an N-bit up/down loadable counter: loads a preset, reloads it at each
// terminal count, and emits tick/wave/done. Optional macro: TIMER_SEQ_CTRL_AUTORESTART_EN.
module timer_seq_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_mode_up,
  input  logic [N-1:0] i_preset,
  input  logic [R-1:0] i_repeats,
  input  logic         i_cnt_co,
  output logic         o_cnt_ld,
  output logic         o_cnt_en,
  output logic         o_cnt_sel,
  output logic [N-1:0] o_cnt_pin,
  output logic         o_busy,
  output logic         o_tick,
  output logic         o_wave,
  output logic         o_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StCount} state_e;

  state_e       r_state, w_state_d;
  logic [N-1:0] r_preset;
  logic         r_mode;
  logic [R-1:0] r_rem;
  logic         r_tick, r_wave, r_done;
  logic         w_event, w_final, w_accept;
`ifdef TIMER_SEQ_CTRL_AUTORESTART_EN
  logic [R-1:0] r_reps;
`endif

  assign w_accept = (r_state == StIdle) && i_start && !i_abort;

  always_comb begin
    w_state_d = r_state;
    o_cnt_ld  = 1'b0;
    o_cnt_en  = 1'b0;
    w_event   = 1'b0;
    w_final   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StLoad;
      end
      StLoad: begin
        o_cnt_ld  = 1'b1;
        w_state_d = i_abort ? StIdle : StCount;
      end
      StCount: begin
        // Reload at terminal count instead of letting the counter wrap.
        if (!i_cnt_co) o_cnt_en = 1'b1;
        else if (r_rem != '0) o_cnt_ld = 1'b1;
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (i_cnt_co) begin
          w_event = 1'b1;
          if (r_rem == '0) begin
            w_final = 1'b1;
`ifdef TIMER_SEQ_CTRL_AUTORESTART_EN
            w_state_d = StLoad;
`else
            w_state_d = StIdle;
`endif
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_preset <= '0;
      r_mode   <= 1'b0;
      r_rem    <= '0;
      r_tick   <= 1'b0;
      r_wave   <= 1'b0;
      r_done   <= 1'b0;
`ifdef TIMER_SEQ_CTRL_AUTORESTART_EN
      r_reps   <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_tick  <= w_event;
      r_done  <= w_final;
      if (w_event) r_wave <= ~r_wave;
      if (w_accept) begin
        r_preset <= i_preset;
        r_mode   <= i_mode_up;
        r_rem    <= i_repeats;
`ifdef TIMER_SEQ_CTRL_AUTORESTART_EN
        r_reps   <= i_repeats;
`endif
      end else if (w_event && !w_final) begin
        r_rem <= r_rem - 1'b1;
      end
`ifdef TIMER_SEQ_CTRL_AUTORESTART_EN
      else if (w_final) begin
        r_rem <= r_reps;
      end
`endif
    end
  end

  assign o_cnt_pin = r_preset;
  assign o_cnt_sel = r_mode;
  assign o_busy    = (r_state != StIdle);
  assign o_tick    = r_tick;
  assign o_wave    = r_wave;
  assign o_done    = r_done;

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
- Control stage directly upstream of the team's N-bit up/down loadable counter.
- Latches a preset, direction and repeat count on a start request. Drives the counter's load/enable/select/parallel-in lines and watches its terminal-count (co) flag.
- Reloads the preset at each terminal count and produces tick, square-wave and done outputs for downstream logic.
- Used for programmable frequency division and interval timing in the lab designs.

Parameters:
- N, 8, width of preset and counter data path.
- R, 4, width of repeat-count field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a run; sampled in IDLE only.
- abort  in  1  synchronous stop; takes precedence over start.
- mode_up  in  1  direction for the run: 1 = count up, 0 = count down.
- preset  in  N  counter reload value.
- repeats  in  R  number of extra periods; a run has repeats+1 terminal events.
- cnt_co  in  1  terminal-count flag from the counter: all-ones when counting up, all-zeros when counting down.
- cnt_ld  out  1  counter load strobe.
- cnt_en  out  1  counter enable.
- cnt_sel  out  1  counter direction select.
- cnt_pin  out  N  counter parallel load value.
- busy  out  1  high in LOAD and COUNT.
- tick  out  1  registered one-cycle pulse per terminal event.
- wave  out  1  registered; toggles on every terminal event.
- done  out  1  registered one-cycle pulse after the final terminal event.

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE.
  - preset_q, mode_q, rem_q cleared to 0.
  - All outputs 0: cnt_ld, cnt_en, cnt_sel, cnt_pin, busy, tick, wave, done.
- Output sourcing:
  - cnt_pin = preset_q and cnt_sel = mode_q at all times; both hold their values after a run.
  - cnt_ld and cnt_en are decoded from state and cnt_co.
  - cnt_co is a registered-state flag in the counter, so there is no combinational loop.
- IDLE:
  - cnt_ld=0, cnt_en=0.
  - If start=1 and abort=0: latch preset, mode_up and repeats into preset_q, mode_q, rem_q; go to LOAD.
- LOAD (one cycle):
  - cnt_ld=1, cnt_en=0; go to COUNT.
  - The counter holds the preset from the first COUNT cycle.
- COUNT, cnt_co=0: cnt_en=1, cnt_ld=0.
- COUNT, cnt_co=1 and rem_q != 0:
  - cnt_ld=1, cnt_en=0 (reload instead of wrap).
  - rem_q decrements; stay in COUNT.
  - tick=1 and wave toggles on the next cycle.
- COUNT, cnt_co=1 and rem_q == 0:
  - cnt_ld=0, cnt_en=0; go to IDLE.
  - On the next cycle: tick=1, wave toggles, done=1, busy=0.
- Period between ticks: 2^N - P cycles for up mode, P+1 cycles for down mode, where P is the latched preset.
- First tick timing: the first terminal cycle is COUNT-cycle index 2^N-1-P (up) or P (down), counted from 0. tick follows one cycle later.
- Preset already terminal (P all-ones when up, 0 when down): the terminal event occurs on the first COUNT cycle. Period is 1 cycle.
- start while busy: ignored. Inputs are not re-latched mid-run.
- abort=1 in LOAD or COUNT:
  - Next state IDLE; cnt_ld=0 and cnt_en=0 from that edge.
  - No tick or done is produced; wave holds its value.
- start and abort together in IDLE: stay in IDLE.
- rst mid-run: immediate return to the reset values on that edge.

Optional Feature:
- Macro: TIMER_SEQ_CTRL_AUTORESTART_EN.
- Defined: on the final terminal event, the FSM goes to LOAD instead of IDLE and reloads rem_q from the latched repeats. done still pulses once per run. busy stays 1. Runs repeat indefinitely until abort or rst.
- Undefined: behaviour exactly as in Behaviour above; return to IDLE after the final event.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, state IDLE.
- N=8, mode_up=1, preset=250, repeats=2, start pulse:
  - -> LOAD for one cycle, then 3 ticks spaced 6 cycles apart; the first tick 6 cycles after the first COUNT cycle.
  - -> wave ends at 1 after three toggles from 0.
  - -> done pulses with the 3rd tick; busy then 0; cnt_ld pulses at the first two terminal cycles only.
- mode_up=0, preset=3, repeats=0 -> cnt_sel=0; one tick 4 cycles after the first COUNT cycle, with done coincident; the counter is never loaded after the terminal.
- preset=255, mode_up=1, repeats=3 -> a tick every cycle for 4 cycles; wave toggles each cycle; done on the 4th.
- abort asserted on the 3rd COUNT cycle of a preset=0, up run -> IDLE next cycle; cnt_en=0, no tick, no done, wave unchanged; a later start is accepted normally.
- With TIMER_SEQ_CTRL_AUTORESTART_EN defined, preset=254, up, repeats=1 -> ticks every 2 cycles with a LOAD cycle inserted after each done; busy stays 1; abort returns to IDLE.
